// File: rtl/crc_engine_if.sv
// Beat-in / result-out bundle for crc_engine: frame input stream, abort, and the
// registered result, status and debug outputs.
interface crc_engine_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DATA_W = 8
);
  logic              clr;
  logic              axiiv;
  logic [DATA_W-1:0] axiid;
  logic              axiil;
  logic              axiov;
  logic [WIDTH-1:0]  axiod;
  logic              crc_ok;
  logic [WIDTH-1:0]  crc_run;
  logic [15:0]       beats;

  modport master (
    output clr, axiiv, axiid, axiil,
    input  axiov, axiod, crc_ok, crc_run, beats
  );

  modport slave (
    input  clr, axiiv, axiid, axiil,
    output axiov, axiod, crc_ok, crc_run, beats
  );
endinterface

// File: rtl/crc_engine.sv
// Frame-aware parametrised CRC engine: one unrolled DATA_W-bit update per beat,
// registered final CRC / residue flag / beat count one cycle after the last beat.
module crc_engine #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] POLY    = 32'h1D,
  parameter logic [31:0] INIT    = 32'hFF,
  parameter bit          REFIN   = 1'b1,
  parameter bit          REFOUT  = 1'b1,
  parameter logic [31:0] XOROUT  = 32'h00,
  parameter logic [31:0] RESIDUE = 32'h00,
  parameter int unsigned DATA_W  = 8
) (
  input logic            clk,
  input logic            rst,
  crc_engine_if.slave    bus
);

  localparam logic [WIDTH-1:0] POLY_W    = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_W    = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] XOROUT_W  = XOROUT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESIDUE_W = RESIDUE[WIDTH-1:0];
  localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  crc_q, crc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [WIDTH-1:0]  od_q, od_d;
  logic              ok_q, ok_d;
  logic [15:0]       beats_q, beats_d;
  logic              arm_q;

  logic              beat_c;
  logic [WIDTH-1:0]  crc_nxt_c;
  logic [15:0]       cnt_inc_c;

  // Whole beat folded into the register in one combinational pass.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [WIDTH-1:0] r;
    logic             b;
    logic             fb;
    r = c;
    for (int i = 0; i < int'(DATA_W); i++) begin
      b  = REFIN ? d[i] : d[int'(DATA_W) - 1 - i];
      fb = r[WIDTH-1] ^ b;
      r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = v[int'(WIDTH) - 1 - i];
    return r;
  endfunction

  assign crc_nxt_c = crc_step(crc_q, bus.axiid);
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
  // arm_q holds off acceptance until the second edge after reset release.
  assign beat_c    = arm_q & bus.axiiv & ~bus.clr;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    ok_d    = ok_q;
    beats_d = beats_q;

    case (state_q)
      IDLE:    if (beat_c && !bus.axiil) state_d = ACTIVE;
      ACTIVE:  if (beat_c && bus.axiil)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.clr) begin
      state_d = IDLE;
      crc_d   = INIT_W;
      cnt_d   = '0;
    end else if (beat_c) begin
      if (bus.axiil) begin
        ov_d    = 1'b1;
        od_d    = (REFOUT ? bitrev(crc_nxt_c) : crc_nxt_c) ^ XOROUT_W;
        ok_d    = (crc_nxt_c == RESIDUE_W);
        beats_d = cnt_inc_c;
        crc_d   = INIT_W;
        cnt_d   = '0;
      end else begin
        crc_d = crc_nxt_c;
        cnt_d = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc_q   <= INIT_W;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ok_q    <= 1'b0;
      beats_q <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      beats_q <= beats_d;
      arm_q   <= 1'b1;
    end
  end

  assign bus.axiov   = ov_q;
  assign bus.axiod   = od_q;
  assign bus.crc_ok  = ok_q;
  assign bus.crc_run = crc_q;
  assign bus.beats   = beats_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: per-beat vector table on the default CRC-8
// instance, plus reset, bit-serial and CRC-16 sequences.
module tb_crc_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_engine_if #(.WIDTH(8),  .DATA_W(8)) b0 ();
  crc_engine_if #(.WIDTH(8),  .DATA_W(1)) b1 ();
  crc_engine_if #(.WIDTH(16), .DATA_W(8)) b2 ();

  crc_engine u0 (.clk(clk), .rst(rst), .bus(b0));
  crc_engine #(.DATA_W(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  crc_engine #(.WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .REFIN(1'b0),
               .REFOUT(1'b0), .XOROUT(32'h0), .RESIDUE(32'h0), .DATA_W(8))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic        v;
    logic        l;
    logic        c;
    logic [7:0]  d;
    logic        eov;
    logic [7:0]  eod;
    logic        eok;
    logic [15:0] ebeats;
    logic        crun;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  msg[9];
  logic [7:0]  h_od;
  logic        h_ok;
  logic [15:0] h_b;
  int          n_checks;
  int          n_fail;
  int          early;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_row(input logic v, input logic l, input logic c,
                         input logic [7:0] d, input logic eov, input logic crun);
    vec_t r;
    r.v = v; r.l = l; r.c = c; r.d = d; r.eov = eov;
    r.eod = h_od; r.eok = h_ok; r.ebeats = h_b; r.crun = crun;
    tbl.push_back(r);
  endtask

  // Frame of msg bytes, optionally with a trailing CRC byte and idle gaps.
  task automatic add_frame(input int gapmax, input logic extra,
                           input logic [7:0] od, input logic ok, input logic [15:0] b);
    int n;
    n = extra ? 10 : 9;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gapmax > 0)
        repeat ($urandom_range(0, gapmax)) add_row(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
      if (i == n - 1) begin
        h_od = od; h_ok = ok; h_b = b;
        add_row(1'b1, 1'b1, 1'b0, extra ? 8'h97 : msg[i], 1'b1, 1'b1);
      end else begin
        add_row(1'b1, 1'b0, 1'b0, msg[i], 1'b0, 1'b0);
      end
    end
  endtask

  task automatic idle_all();
    b0.axiiv = 1'b0; b0.axiil = 1'b0; b0.clr = 1'b0; b0.axiid = '0;
    b1.axiiv = 1'b0; b1.axiil = 1'b0; b1.clr = 1'b0; b1.axiid = '0;
    b2.axiiv = 1'b0; b2.axiil = 1'b0; b2.clr = 1'b0; b2.axiid = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t, limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; early = 0;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    idle_all();
    h_od = 8'h00; h_ok = 1'b0; h_b = 16'd0;

    add_frame(0, 1'b0, 8'h97, 1'b0, 16'd9);
    add_frame(0, 1'b1, 8'h00, 1'b1, 16'd10);
    add_frame(5, 1'b0, 8'h97, 1'b0, 16'd9);
    add_frame(5, 1'b0, 8'h97, 1'b0, 16'd9);
    for (int i = 0; i < 4; i++) add_row(1'b1, 1'b0, 1'b0, msg[i], 1'b0, 1'b0);
    add_row(1'b1, 1'b1, 1'b1, 8'h39, 1'b0, 1'b1);
    add_frame(0, 1'b0, 8'h97, 1'b0, 16'd9);

    // Asynchronous reset values, before any clock edge sees them.
    #2 rst = 1'b0;
    #1;
    check("rst axiov",   32'(b0.axiov),   32'h0);
    check("rst axiod",   32'(b0.axiod),   32'h0);
    check("rst crc_ok",  32'(b0.crc_ok),  32'h0);
    check("rst beats",   32'(b0.beats),   32'h0);
    check("rst crc_run", 32'(b0.crc_run), 32'hFF);
    check("rst crc_run16", 32'(b2.crc_run), 32'hFFFF);

    // Beat at the first edge after release must be ignored.
    @(negedge clk);
    rst = 1'b1;
    b0.axiiv = 1'b1; b0.axiil = 1'b1; b0.axiid = 8'h39;
    @(posedge clk); #1;
    check("edge1 beat ignored axiov", 32'(b0.axiov), 32'h0);
    check("edge1 beat ignored run",   32'(b0.crc_run), 32'hFF);

    foreach (tbl[i]) begin
      @(negedge clk);
      b0.axiiv = tbl[i].v; b0.axiil = tbl[i].l; b0.clr = tbl[i].c; b0.axiid = tbl[i].d;
      @(posedge clk); #1;
      check($sformatf("row%0d axiov", i),  32'(b0.axiov),  32'(tbl[i].eov));
      check($sformatf("row%0d axiod", i),  32'(b0.axiod),  32'(tbl[i].eod));
      check($sformatf("row%0d crc_ok", i), 32'(b0.crc_ok), 32'(tbl[i].eok));
      check($sformatf("row%0d beats", i),  32'(b0.beats),  32'(tbl[i].ebeats));
      if (tbl[i].crun)
        check($sformatf("row%0d crc_run", i), 32'(b0.crc_run), 32'hFF);
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    check("strobe falls", 32'(b0.axiov), 32'h0);

    // Reset mid-frame: outputs clear at once, partial frame is lost.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b0.axiiv = 1'b1; b0.axiil = 1'b0; b0.axiid = msg[i];
    end
    @(posedge clk);
    #2 rst = 1'b0;
    b0.axiiv = 1'b0;
    #1;
    check("midrst axiov",   32'(b0.axiov),   32'h0);
    check("midrst axiod",   32'(b0.axiod),   32'h0);
    check("midrst crc_ok",  32'(b0.crc_ok),  32'h0);
    check("midrst beats",   32'(b0.beats),   32'h0);
    check("midrst crc_run", 32'(b0.crc_run), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b0.axiiv = 1'b1; b0.axiil = (i == 8); b0.axiid = msg[i];
      @(posedge clk); #1;
      if (i < 8 && b0.axiov) early++;
    end
    check("postrst early strobes", 32'(early), 32'h0);
    check("postrst axiov", 32'(b0.axiov), 32'h1);
    check("postrst axiod", 32'(b0.axiod), 32'h97);
    check("postrst beats", 32'(b0.beats), 32'd9);

    // Reset during the strobe cycle drops axiov immediately.
    b0.axiiv = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("strobe rst axiov", 32'(b0.axiov), 32'h0);
    check("strobe rst axiod", 32'(b0.axiod), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    @(posedge clk);

    // Bit-serial: 72 bits, each byte LSB first.
    early = 0;
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        b1.axiiv = 1'b1; b1.axiid = msg[j][k]; b1.axiil = (j == 8 && k == 7);
        @(posedge clk); #1;
        if (!(j == 8 && k == 7) && b1.axiov) early++;
      end
    end
    check("serial early strobes", 32'(early), 32'h0);
    check("serial axiov",  32'(b1.axiov),  32'h1);
    check("serial axiod",  32'(b1.axiod),  32'h97);
    check("serial crc_ok", 32'(b1.crc_ok), 32'h0);
    check("serial beats",  32'(b1.beats),  32'd72);
    check("serial crc_run", 32'(b1.crc_run), 32'hFF);
    @(negedge clk);
    b1.axiiv = 1'b0; b1.axiil = 1'b0;

    // CRC-16, non-reflected, MSB-first bytes.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b2.axiiv = 1'b1; b2.axiil = (i == 8); b2.axiid = msg[i];
    end
    @(posedge clk); #1;
    check("crc16 axiov",  32'(b2.axiov),  32'h1);
    check("crc16 axiod",  32'(b2.axiod),  32'h29B1);
    check("crc16 crc_ok", 32'(b2.crc_ok), 32'h0);
    check("crc16 beats",  32'(b2.beats),  32'd9);
    check("crc16 crc_run", 32'(b2.crc_run), 32'hFFFF);
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    check("crc16 strobe falls", 32'(b2.axiov), 32'h0);
    check("crc16 axiod held",   32'(b2.axiod), 32'h29B1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised, frame-aware CRC engine that replaces the fixed serial CRC8 checker in the optical link receive and transmit paths. It accepts 1 to 32 data bits per beat and supports any polynomial up to 32 bits, with configurable init, reflection and xorout. It delimits frames with a last flag and emits a registered final CRC plus a residue-match flag one cycle after the last beat. It then re-arms automatically for back-to-back frames.

## Interface
- WIDTH, 8: CRC width in bits; legal 8..32.
- POLY, 'h1D: generator polynomial, normal (non-reflected) form, implicit x^WIDTH term.
- INIT, 'hFF: register load value at reset, after `clr` and after each frame.
- REFIN, 1: 1 = `axiid[0]` processed first; 0 = `axiid[DATA_W-1]` processed first.
- REFOUT, 1: 1 = bit-reverse the register before xorout.
- XOROUT, 'h00: final XOR mask.
- RESIDUE, 'h00: expected raw register value after a frame that includes its own appended CRC.
- DATA_W, 8: bits per beat; legal 1..32.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous frame abort; reloads INIT and discards the current frame.
- axiiv  in  1  input beat valid.
- axiid  in  DATA_W  input beat data.
- axiil  in  1  last beat of frame; sampled only with `axiiv`.
- axiov  out  1  one-cycle result strobe.
- axiod  out  WIDTH  final CRC; held until the next strobe.
- crc_ok  out  1  raw register equalled RESIDUE at end of frame; held with `axiod`.
- crc_run  out  WIDTH  raw running register, for debug and legacy bit-serial users.
- beats  out  16  beat count of the last completed frame; held with `axiod`.

## Operation
- Per-bit step, applied DATA_W times per accepted beat, in the order set by REFIN:
  - fb = crc[WIDTH-1] ^ bit
  - crc = {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- The whole beat must be one combinational unrolled update per clock. No multi-cycle beats.
- Final value = (REFOUT ? bitrev(crc_next) : crc_next) ^ XOROUT, where crc_next is the register after the last beat.
- crc_ok = (crc_next == RESIDUE). The compare uses the raw register, not the final value.
- FSM has two states:
  - IDLE: register = INIT, beat counter = 0.
  - ACTIVE: at least one beat accepted.
  - IDLE -> ACTIVE on `axiiv & ~axiil`.
  - ACTIVE -> IDLE on `axiiv & axiil`, or on `clr`.
  - IDLE with `axiiv & axiil` is a single-beat frame. It produces a result and stays in IDLE.
- On the last beat, the final value, crc_ok and the beat count (saturating at 16'hFFFF) are latched. In the same edge, the register reloads INIT and the counter clears.
- `axiiv` low: the register and counter hold. Gaps of any length inside a frame are legal.
- `clr` has priority over `axiiv`. A beat presented with `clr` is dropped, and no strobe is produced even if `axiil` is set. Held outputs are unchanged.
- `axiov` is not back-pressured. The downstream consumer must accept every strobe.

## Timing
- Reset (rst = 0, asynchronous) forces the following immediately, independent of clk:
  - crc_run = INIT, state IDLE, counter 0
  - axiov = 0, axiod = 0, crc_ok = 0, beats = 0
- Release of rst is synchronised internally; the first beat is accepted on the second rising edge after deassertion.
- Latency: last beat sampled at edge N -> `axiov` = 1 and `axiod`/`crc_ok`/`beats` valid during cycle N+1. `axiov` falls at N+2 unless another last beat was accepted at N+1.
- Throughput is one beat per cycle. A first beat of the next frame in cycle N+1 is accepted against INIT. Strobes on consecutive cycles are legal (single-beat frames).
- `crc_run` updates at the edge that accepts a beat and shows INIT in the cycle after a last beat.
- Reset asserted mid-frame: the frame is lost and no strobe is produced. Asserted during a strobe cycle: `axiov` drops immediately.

## Test plan
- Defaults, ASCII "123456789" as 9 beats (axiid = 8'h31..8'h39), last on 8'h39: `axiov` one cycle later with axiod = 8'h97, crc_ok = 0, beats = 9.
- Same 9 bytes plus a 10th beat 8'h97 with last: axiod = 8'h00, crc_ok = 1, beats = 10.
- Same frame with random 0-5 cycle `axiiv` gaps, sent twice back-to-back with no idle cycle: two strobes, both with axiod = 8'h97. `crc_run` = 8'hFF in the cycle after each last beat.
- Partial frame of 4 bytes, then `clr` with `axiiv` and `axiil` high, then the full "123456789": exactly one strobe, axiod = 8'h97. A separate run asserts rst mid-frame and checks all outputs are zero immediately, with no strobe.
- DATA_W=1, other parameters default: 72 serial bits of "123456789", each byte LSB first, last on the 72nd bit: axiod = 8'h97, beats = 72 (legacy bit-serial equivalence).
- WIDTH=16, POLY='h1021, INIT='hFFFF, REFIN=0, REFOUT=0, XOROUT=0, DATA_W=8, same 9 bytes: axiod = 16'h29B1.
